boid_frame_scheduler: RTL and testbench

- Once per video frame, sweeps every boid entry in the boid state RAM and advances each boid's position by its velocity.
- Wraps positions at the 640x480 screen edges and writes each entry back.
- Sits between the VGA timing generator's frame-end pulse and the single-port boid state RAM.
- Owns that RAM port during the sweep and flags busy so the sprite renderer does not read mid-update.

---
 rtl/boid_frame_scheduler.sv | 166 ++++++++++++++++
 tb/tb_boid_frame_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_scheduler.sv
// Per-frame boid position sweep over the single-port boid state RAM.
// Optional macro BOID_BOUNCE_EN: reflect at screen edges instead of wrapping.
//
// state   | meaning
// IDLE    | waiting for a screenEnd rising edge
// READ    | read strobe for the current entry
// WAIT    | RAM data returns, captured at the end of the cycle
// CALC    | new position (and velocity) registered onto the write bus
// WRITE   | write strobe for the current entry
// DONE    | one-cycle done pulse, frame counter advances
module boid_frame_scheduler #(
   parameter int NUM_BOIDS = 16,
   parameter int ADDR_W    = 4,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int V_W       = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         screenEnd,
   input  logic                         pause,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic                         mem_rd_en,
   input  logic [2*V_W+X_W+Y_W-1:0]     mem_rd_data,
   output logic                         mem_wr_en,
   output logic [2*V_W+X_W+Y_W-1:0]     mem_wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         overrun,
   output logic [15:0]                  frame_count
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE, S_DONE} state_t;

   localparam logic signed [X_W:0] MOD_X = (X_W+1)'(SCREEN_W);
   localparam logic signed [Y_W:0] MOD_Y = (Y_W+1)'(SCREEN_H);
   localparam logic [ADDR_W-1:0]   LAST  = ADDR_W'(NUM_BOIDS-1);

   state_t            state;
   logic [ADDR_W-1:0] index;
   logic              screen_end_q;
   logic [X_W-1:0]    cur_x;
   logic [Y_W-1:0]    cur_y;
   logic [V_W-1:0]    cur_vx, cur_vy;

   logic              start_edge;
   logic signed [X_W:0] sum_x;
   logic signed [Y_W:0] sum_y;
   logic [X_W-1:0]    new_x;
   logic [Y_W-1:0]    new_y;
   logic [V_W-1:0]    new_vx, new_vy;

   assign start_edge = screenEnd & ~screen_end_q & ~pause;

   // Negation of the most-negative velocity saturates to the most-positive.
   function automatic logic [V_W-1:0] neg_sat(input logic [V_W-1:0] v);
      if (v == {1'b1, {(V_W-1){1'b0}}})
         return {1'b0, {(V_W-1){1'b1}}};
      return -v;
   endfunction

   always_comb begin
      sum_x  = $signed({1'b0, cur_x}) + $signed({{(X_W+1-V_W){cur_vx[V_W-1]}}, cur_vx});
      sum_y  = $signed({1'b0, cur_y}) + $signed({{(Y_W+1-V_W){cur_vy[V_W-1]}}, cur_vy});
      new_x  = cur_x;
      new_y  = cur_y;
      new_vx = cur_vx;
      new_vy = cur_vy;
`ifdef BOID_BOUNCE_EN
      if (sum_x < 0) begin
         new_x  = X_W'(-sum_x);
         new_vx = neg_sat(cur_vx);
      end else if (sum_x >= MOD_X) begin
         new_x  = X_W'(2*(MOD_X-1) - sum_x);
         new_vx = neg_sat(cur_vx);
      end else
         new_x  = X_W'(sum_x);
      if (sum_y < 0) begin
         new_y  = Y_W'(-sum_y);
         new_vy = neg_sat(cur_vy);
      end else if (sum_y >= MOD_Y) begin
         new_y  = Y_W'(2*(MOD_Y-1) - sum_y);
         new_vy = neg_sat(cur_vy);
      end else
         new_y  = Y_W'(sum_y);
`else
      if (sum_x < 0)
         new_x = X_W'(sum_x + MOD_X);
      else if (sum_x >= MOD_X)
         new_x = X_W'(sum_x - MOD_X);
      else
         new_x = X_W'(sum_x);
      if (sum_y < 0)
         new_y = Y_W'(sum_y + MOD_Y);
      else if (sum_y >= MOD_Y)
         new_y = Y_W'(sum_y - MOD_Y);
      else
         new_y = Y_W'(sum_y);
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         index        <= '0;
         screen_end_q <= 1'b0;
         cur_x        <= '0;
         cur_y        <= '0;
         cur_vx       <= '0;
         cur_vy       <= '0;
         mem_addr     <= '0;
         mem_rd_en    <= 1'b0;
         mem_wr_en    <= 1'b0;
         mem_wr_data  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         overrun      <= 1'b0;
         frame_count  <= '0;
      end else begin
         screen_end_q <= screenEnd;
         mem_rd_en    <= 1'b0;
         mem_wr_en    <= 1'b0;
         done         <= 1'b0;
         if (start_edge && state != S_IDLE)
            overrun <= 1'b1;
         case (state)
            S_IDLE: if (start_edge) begin
               index     <= '0;
               mem_addr  <= '0;
               mem_rd_en <= 1'b1;
               busy      <= 1'b1;
               state     <= S_READ;
            end
            S_READ: state <= S_WAIT;
            S_WAIT: begin
               {cur_vy, cur_vx, cur_y, cur_x} <= mem_rd_data;
               state <= S_CALC;
            end
            S_CALC: begin
               mem_addr    <= index;
               mem_wr_en   <= 1'b1;
               mem_wr_data <= {new_vy, new_vx, new_y, new_x};
               state       <= S_WRITE;
            end
            S_WRITE: if (index == LAST) begin
               done  <= 1'b1;
               state <= S_DONE;
            end else begin
               index     <= index + 1'b1;
               mem_addr  <= index + 1'b1;
               mem_rd_en <= 1'b1;
               state     <= S_READ;
            end
            S_DONE: begin
               frame_count <= frame_count + 16'd1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Directed bench for boid_frame_scheduler with a 4-entry behavioural RAM.
module tb_boid_frame_scheduler;
   localparam int NB = 4;
   localparam int AW = 2;
   localparam int XW = 10;
   localparam int YW = 9;
   localparam int VW = 4;
   localparam int DW = 2*VW+XW+YW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          screenEnd = 1'b0;
   logic          pause = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rd_data = '0;
   logic          mem_wr_en;
   logic [DW-1:0] mem_wr_data;
   logic          busy, done, overrun;
   logic [15:0]   frame_count;

   int tests = 0;
   int fails = 0;

   boid_frame_scheduler #(.NUM_BOIDS(NB), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .screenEnd(screenEnd), .pause(pause),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
      .busy(busy), .done(done), .overrun(overrun), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [NB];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;

   always @(posedge clk) begin
      if (ld_en)
         ram[ld_addr] <= ld_data;
      else if (mem_wr_en)
         ram[mem_addr] <= mem_wr_data;
      if (mem_rd_en)
         mem_rd_data <= ram[mem_addr];
   end

   // Bus activity monitor; counts what the DUT drove during each cycle.
   logic mon_clr = 1'b0;
   int   busy_cyc, done_cnt, rd_cnt, wr_cnt, both_cnt, order_err;
   logic expect_wr;
   always @(posedge clk) begin
      if (mon_clr) begin
         busy_cyc <= 0; done_cnt <= 0; rd_cnt <= 0; wr_cnt <= 0;
         both_cnt <= 0; order_err <= 0; expect_wr <= 1'b0;
      end else begin
         if (busy)      busy_cyc <= busy_cyc + 1;
         if (done)      done_cnt <= done_cnt + 1;
         if (mem_rd_en) rd_cnt   <= rd_cnt + 1;
         if (mem_wr_en) wr_cnt   <= wr_cnt + 1;
         if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
         if (mem_rd_en) begin
            if (expect_wr) order_err <= order_err + 1;
            expect_wr <= 1'b1;
         end else if (mem_wr_en) begin
            if (!expect_wr) order_err <= order_err + 1;
            expect_wr <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pk(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                         input logic [VW-1:0] vx, input logic [VW-1:0] vy);
      return {vy, vx, y, x};
   endfunction

   logic [DW-1:0] init_tab [NB];
   logic [DW-1:0] exp_tab  [NB];

   task automatic load_ram();
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         ld_en = 1'b1; ld_addr = AW'(i); ld_data = init_tab[i];
      end
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic clear_mon();
      @(negedge clk);
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check({tag, "_timeout"}, 32'd1, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic sweep();
      @(negedge clk);
      screenEnd = 1'b1;
      @(negedge clk);
      screenEnd = 1'b0;
      wait_idle("sweep");
   endtask

   task automatic check_ram(input string tag);
      for (int i = 0; i < NB; i++)
         check($sformatf("%s_ram%0d", tag, i), 32'(ram[i]), 32'(exp_tab[i]));
   endtask

   initial begin
      init_tab[0] = pk(10'd639, 9'd10,  4'd1,  4'd0);
      init_tab[1] = pk(10'd0,   9'd20,  4'hF,  4'd0);
      init_tab[2] = pk(10'd50,  9'd479, 4'd0,  4'd2);
      init_tab[3] = pk(10'd100, 9'd200, 4'hD,  4'd5);
`ifdef BOID_BOUNCE_EN
      exp_tab[0]  = pk(10'd638, 9'd10,  4'hF,  4'd0);
      exp_tab[1]  = pk(10'd1,   9'd20,  4'd1,  4'd0);
      exp_tab[2]  = pk(10'd50,  9'd477, 4'd0,  4'hE);
`else
      exp_tab[0]  = pk(10'd0,   9'd10,  4'd1,  4'd0);
      exp_tab[1]  = pk(10'd639, 9'd20,  4'hF,  4'd0);
      exp_tab[2]  = pk(10'd50,  9'd1,   4'd0,  4'd2);
`endif
      exp_tab[3]  = pk(10'd97,  9'd205, 4'hD,  4'd5);

      repeat (3) @(negedge clk);
      check("rst_busy",    32'(busy), 0);
      check("rst_done",    32'(done), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_fc",      32'(frame_count), 0);
      check("rst_rd_en",   32'(mem_rd_en), 0);
      check("rst_wr_en",   32'(mem_wr_en), 0);
      check("rst_addr",    32'(mem_addr), 0);
      reset = 1'b1;

      // Basic sweep: wrap at each edge, velocities preserved.
      load_ram();
      clear_mon();
      sweep();
      check("s1_busy_cyc", 32'(busy_cyc), 17);
      check("s1_done_cnt", 32'(done_cnt), 1);
      check("s1_fc",       32'(frame_count), 1);
      check("s1_rd_cnt",   32'(rd_cnt), 4);
      check("s1_wr_cnt",   32'(wr_cnt), 4);
      check("s1_both",     32'(both_cnt), 0);
      check("s1_order",    32'(order_err), 0);
      check_ram("s1");

`ifdef BOID_BOUNCE_EN
      begin
         logic [DW-1:0] b0, b1;
         b0 = pk(10'd638, 9'd30, 4'd3, 4'd0);
         b1 = pk(10'd1,   9'd40, 4'h8, 4'd0);
         init_tab[0] = b0;
         init_tab[1] = b1;
         exp_tab[0]  = pk(10'd637, 9'd30, 4'hD, 4'd0);
         exp_tab[1]  = pk(10'd7,   9'd40, 4'd7, 4'd0);
         load_ram();
         sweep();
         check("bounce_ram0", 32'(ram[0]), 32'(exp_tab[0]));
         check("bounce_ram1", 32'(ram[1]), 32'(exp_tab[1]));
         init_tab[0] = pk(10'd639, 9'd10, 4'd1, 4'd0);
         init_tab[1] = pk(10'd0,   9'd20, 4'hF, 4'd0);
         exp_tab[0]  = pk(10'd638, 9'd10, 4'hF, 4'd0);
         exp_tab[1]  = pk(10'd1,   9'd20, 4'd1, 4'd0);
      end
`endif

      // Second edge mid-sweep: flagged as overrun, sweep continues untouched.
      do_reset();
      load_ram();
      clear_mon();
      @(negedge clk);
      screenEnd = 1'b1;
      @(negedge clk);
      screenEnd = 1'b0;
      repeat (4) @(negedge clk);
      screenEnd = 1'b1;
      @(negedge clk);
      screenEnd = 1'b0;
      check("ov_flag_mid", 32'(overrun), 1);
      wait_idle("ov");
      check("ov_flag",     32'(overrun), 1);
      check("ov_busy_cyc", 32'(busy_cyc), 17);
      check("ov_wr_cnt",   32'(wr_cnt), 4);
      check("ov_fc",       32'(frame_count), 1);
      check_ram("ov");

      // Paused edge is ignored without overrun; next unpaused edge sweeps.
      do_reset();
      load_ram();
      clear_mon();
      pause = 1'b1;
      @(negedge clk);
      screenEnd = 1'b1;
      @(negedge clk);
      screenEnd = 1'b0;
      repeat (30) @(negedge clk);
      check("pz_busy_cyc", 32'(busy_cyc), 0);
      check("pz_rd_cnt",   32'(rd_cnt), 0);
      check("pz_wr_cnt",   32'(wr_cnt), 0);
      check("pz_overrun",  32'(overrun), 0);
      check("pz_fc",       32'(frame_count), 0);
      pause = 1'b0;
      sweep();
      check("pz_fc_after", 32'(frame_count), 1);
      check("pz_wr_after", 32'(wr_cnt), 4);
      check("pz_busy_aft", 32'(busy_cyc), 17);
      check_ram("pz");

      // Reset lands as boid 2 would enter WRITE: boids 2 and 3 stay intact.
      do_reset();
      load_ram();
      @(negedge clk);
      screenEnd = 1'b1;
      @(negedge clk);
      screenEnd = 1'b0;
      check("mr_busy_start", 32'(busy), 1);
      repeat (10) @(negedge clk);
      check("mr_calc_addr", 32'(mem_addr), 2);
      check("mr_calc_wr",   32'(mem_wr_en), 0);
      reset = 1'b0;
      @(negedge clk);
      check("mr_wr_en", 32'(mem_wr_en), 0);
      check("mr_busy",  32'(busy), 0);
      check("mr_fc",    32'(frame_count), 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("mr_ram0", 32'(ram[0]), 32'(exp_tab[0]));
      check("mr_ram1", 32'(ram[1]), 32'(exp_tab[1]));
      check("mr_ram2", 32'(ram[2]), 32'(init_tab[2]));
      check("mr_ram3", 32'(ram[3]), 32'(init_tab[3]));
      check("mr_idle", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
